// File: rtl/dac_playback_pkg.sv
// dac_playback_pkg: shared state type and sizing constants for the DAC playback block
package dac_playback_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;
    localparam int DATA_WIDTH = 128;
    localparam int SAMPLES_PER_BEAT = 8;
    localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/dac_playback_ram.sv
// dac_playback_ram: simple dual-port sample memory, read-first, two-cycle registered read
module dac_playback_ram #(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] q1;
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) q1 <= mem[rd_addr];
        rd_data <= q1;
    end
endmodule

// File: rtl/dac_playback.sv
// dac_playback: AXI4-Stream DAC waveform source replaying a loaded sample memory, one-shot or looped
module dac_playback #(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = dac_playback_pkg::DATA_WIDTH
) (
    input  logic                  aclk,
    input  logic                  aclk_rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  cfg_length,
    input  logic                  cfg_loop,
    input  logic                  cfg_sync,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sysref,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  armed,
    output logic                  done,
    output logic [15:0]           loop_count
);
    import dac_playback_pkg::*;
    localparam int PW = $clog2(FIFO_DEPTH);
    state_t state, state_n;
    logic sysref_q, take, issue, last_rd, accept, last_out, v1, v2, rd_done, loop_q, lp;
    logic [ADDR_BITS-1:0] rd_addr, rd_addr_c, len_q, rd_len, out_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [PW+1:0] occ;

    // The first read is issued in the take cycle itself so the first beat lands three cycles later
    assign take = ~stop & ((state == IDLE & start & ~cfg_sync) | (state == ARMED & sysref & ~sysref_q));
    assign rd_len = (state == IDLE) ? cfg_length : len_q;
    assign lp = (state == IDLE) ? cfg_loop : loop_q;
    assign rd_addr_c = take ? '0 : rd_addr;
    assign last_rd = rd_addr_c == rd_len;
    assign occ = {1'b0, cnt} + (PW+2)'(v1) + (PW+2)'(v2);
    assign issue = take | (state == PLAY & ~rd_done & ~stop & occ < (PW+2)'(FIFO_DEPTH));
    assign m_axis_tvalid = cnt != '0;
    assign m_axis_tdata = m_axis_tvalid ? fifo[rp] : '0;
    assign accept = m_axis_tvalid & m_axis_tready;
    assign last_out = accept & (out_idx == len_q);
    assign done = last_out & ~loop_q & (state == PLAY);
    assign busy = state != IDLE;
    assign armed = state == ARMED;

    always_comb begin
        state_n = stop ? IDLE : take ? PLAY : (state == IDLE && start) ? ARMED : done ? IDLE : state;
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state <= IDLE;
            sysref_q <= 1'b0;
            len_q <= '0;
            loop_q <= 1'b0;
        end else begin
            state <= state_n;
            sysref_q <= sysref;
            if (state == IDLE && start) begin
                len_q <= cfg_length;
                loop_q <= cfg_loop;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst || stop) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            cnt <= '0;
            wp <= '0;
            rp <= '0;
            rd_addr <= '0;
            rd_done <= 1'b0;
            out_idx <= '0;
            loop_count <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            wp <= wp + PW'(v2);
            rp <= rp + PW'(accept);
            cnt <= cnt + (PW+1)'(v2) - (PW+1)'(accept);
            if (issue) begin
                rd_addr <= last_rd ? '0 : rd_addr_c + ADDR_BITS'(1);
                rd_done <= last_rd & ~lp;
            end
            if (take) begin
                out_idx <= '0;
                loop_count <= '0;
            end else if (accept) begin
                out_idx <= last_out ? '0 : out_idx + ADDR_BITS'(1);
                if (last_out && loop_q && loop_count != 16'hFFFF) loop_count <= loop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (v2) fifo[wp] <= rd_data;
    end

    dac_playback_ram #(.ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_dac_playback.sv
// tb_dac_playback: directed self-checking bench for dac_playback
module tb_dac_playback;
    localparam int AB = 12;
    localparam int DW = 128;
    logic aclk = 1'b0, aclk_rst = 1'b1, wr_en = 1'b0, cfg_loop = 1'b0, cfg_sync = 1'b0;
    logic start = 1'b0, stop = 1'b0, sysref = 1'b0, m_axis_tready = 1'b1;
    logic [AB-1:0] wr_addr = '0, cfg_length = '0;
    logic [DW-1:0] wr_data = '0, m_axis_tdata, prev;
    logic m_axis_tvalid, busy, armed, done, stalled;
    logic [15:0] loop_count;
    int checks = 0, errors = 0, got, cyc;

    always #5 aclk = ~aclk;

    dac_playback #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .aclk_rst      (aclk_rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cfg_length    (cfg_length),
        .cfg_loop      (cfg_loop),
        .cfg_sync      (cfg_sync),
        .start         (start),
        .stop          (stop),
        .sysref        (sysref),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .armed         (armed),
        .done          (done),
        .loop_count    (loop_count)
    );

    function automatic logic [DW-1:0] w(input int i);
        logic [15:0] s;
        s = 16'(i * 257);
        return {8{s}};
    endfunction

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    initial begin
        repeat (3) step();
        chkb("rst_tvalid", m_axis_tvalid, 1'b0);
        chkw("rst_tdata", m_axis_tdata, '0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_armed", armed, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkw("rst_loop_count", DW'(loop_count), '0);
        aclk_rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1;
            wr_addr = AB'(i);
            wr_data = w(i);
            step();
        end
        wr_en = 1'b0;

        cfg_length = 7; cfg_loop = 1'b0; cfg_sync = 1'b0; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            start = 1'b0;
            if (k < 3) chkb("os_pre_tvalid", m_axis_tvalid, 1'b0);
            else if (k <= 10) begin
                chkb("os_tvalid", m_axis_tvalid, 1'b1);
                chkw("os_data", m_axis_tdata, w(k - 3));
                chkb("os_done", done, k == 10);
            end else begin
                chkb("os_end_tvalid", m_axis_tvalid, 1'b0);
                chkb("os_end_busy", busy, 1'b0);
            end
        end

        cfg_length = 3; cfg_loop = 1'b1; start = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            step();
            start = 1'b0;
            if (k >= 3 && k <= 42) begin
                chkb("loop_tvalid", m_axis_tvalid, 1'b1);
                chkw("loop_data", m_axis_tdata, w((k - 3) % 4));
            end
            if (k == 7) chkw("loop_count_1", DW'(loop_count), DW'(1));
        end
        chkw("loop_count_10", DW'(loop_count), DW'(10));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chkb("stop_tvalid", m_axis_tvalid, 1'b0);
        chkw("stop_tdata", m_axis_tdata, '0);
        chkb("stop_busy", busy, 1'b0);
        chkw("stop_loop_count", DW'(loop_count), '0);
        repeat (3) step();
        chkb("stop_flushed", m_axis_tvalid, 1'b0);

        cfg_length = 255; cfg_loop = 1'b0; start = 1'b1;
        got = 0; cyc = 0; stalled = 1'b0; prev = '0;
        step();
        start = 1'b0;
        while (got < 256 && cyc < 3000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                chkb("bp_hold_tvalid", m_axis_tvalid, 1'b1);
                chkw("bp_hold_data", m_axis_tdata, prev);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chkw("bp_data", m_axis_tdata, w(got));
                chkb("bp_done", done, got == 255);
                got++;
            end
            stalled = m_axis_tvalid & ~m_axis_tready;
            prev = m_axis_tdata;
            step();
            cyc++;
        end
        m_axis_tready = 1'b1;
        chkw("bp_count", DW'(got), DW'(256));
        chkb("bp_end_tvalid", m_axis_tvalid, 1'b0);
        chkb("bp_end_busy", busy, 1'b0);

        cfg_length = 1; cfg_loop = 1'b0; cfg_sync = 1'b1; sysref = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            start = k == 5;
            cfg_length = 5;
            cfg_sync = 1'b0;
            chkb("sync_armed", armed, 1'b1);
            chkb("sync_tvalid", m_axis_tvalid, 1'b0);
        end
        start = 1'b0;
        sysref = 1'b1;
        step();
        chkb("sync_t1_armed", armed, 1'b0);
        chkb("sync_t1_busy", busy, 1'b1);
        chkb("sync_t1_tvalid", m_axis_tvalid, 1'b0);
        step();
        chkb("sync_t2_tvalid", m_axis_tvalid, 1'b0);
        step();
        chkb("sync_t3_tvalid", m_axis_tvalid, 1'b1);
        chkw("sync_t3_data", m_axis_tdata, w(0));
        step();
        chkw("sync_t4_data", m_axis_tdata, w(1));
        chkb("sync_t4_done", done, 1'b1);
        step();
        chkb("sync_t5_tvalid", m_axis_tvalid, 1'b0);
        chkb("sync_t5_busy", busy, 1'b0);
        sysref = 1'b0;

        cfg_length = 0; cfg_loop = 1'b0; start = 1'b1;
        repeat (3) begin
            step();
            start = 1'b0;
        end
        chkb("len0_tvalid", m_axis_tvalid, 1'b1);
        chkb("len0_done", done, 1'b1);
        step();
        chkb("len0_end_tvalid", m_axis_tvalid, 1'b0);
        chkb("len0_end_busy", busy, 1'b0);

        cfg_loop = 1'b1; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            start = 1'b0;
            if (k >= 3) chkb("len0_loop_tvalid", m_axis_tvalid, 1'b1);
        end
        chkw("len0_loop_count", DW'(loop_count), DW'(5));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chkb("len0_loop_stop", m_axis_tvalid, 1'b0);

        cfg_loop = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chkb("startstop_busy", busy, 1'b0);
        repeat (3) step();
        chkb("startstop_tvalid", m_axis_tvalid, 1'b0);

        cfg_length = 7; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            start = 1'b0;
            if (k == 4) chkw("rstplay_data", m_axis_tdata, w(1));
        end
        aclk_rst = 1'b1;
        step();
        chkb("rstplay_tvalid", m_axis_tvalid, 1'b0);
        chkw("rstplay_tdata", m_axis_tdata, '0);
        chkb("rstplay_busy", busy, 1'b0);
        chkb("rstplay_done", done, 1'b0);
        chkw("rstplay_loop_count", DW'(loop_count), '0);
        aclk_rst = 1'b0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            start = 1'b0;
            if (k == 3) chkw("replay_w0", m_axis_tdata, w(0));
            if (k == 4) chkw("replay_w1", m_axis_tdata, w(1));
        end
        chkb("replay_tvalid", m_axis_tvalid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
